// File: rtl/perf_pkg.sv
// Shared helpers for the performance counter bank.
package perf_pkg;

   // Channel-select width: clog2 of the channel count, never narrower than one bit.
   function automatic int sel_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/perf_counter_ch.sv
// One event counter channel: wrap or saturate on overflow, sticky overflow flag,
// clear-on-read that keeps the event arriving in the read cycle.
module perf_counter_ch #(
   parameter int CNT_W    = 8,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr_on_rd,
   output logic [CNT_W-1:0] count,
   output logic             ovf
);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         ovf   <= 1'b0;
      end else if (clr_on_rd) begin
         // The snapshot took the old value; an event in this cycle starts the new window.
         count <= CNT_W'(inc);
         ovf   <= 1'b0;
      end else if (inc) begin
         if (&count) begin
            ovf <= 1'b1;
            if (!SATURATE) count <= '0;
         end else begin
            count <= count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters with a registered, clear-on-read software read port.
module perf_counter_bank
   import perf_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 8,
   parameter bit SATURATE = 1'b0,
   parameter int SEL_W    = sel_w(NUM_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] cpu_trig_i,
   input  logic              cnt_en_i,
   input  logic              sw_req_i,
   input  logic [SEL_W-1:0]  sw_sel_i,
   output logic              p_valid_o,
   output logic [CNT_W-1:0]  p_count_o,
   output logic              p_ovf_o,
   output logic              p_err_o
);

   typedef struct packed {
      logic             valid;
      logic [CNT_W-1:0] count;
      logic             ovf;
      logic             err;
   } perf_rd_rsp_t;

   logic [NUM_CH-1:0]            inc;
   logic [NUM_CH-1:0]            clr;
   logic [NUM_CH-1:0][CNT_W-1:0] cnt;
   logic [NUM_CH-1:0]            ovf;
   perf_rd_rsp_t                 rsp_d, rsp_q;

   assign inc = cpu_trig_i & {NUM_CH{cnt_en_i}};

   // A request that matches no channel leaves err set and count/ovf at zero.
   always_comb begin
      clr         = '0;
      rsp_d       = '0;
      rsp_d.valid = sw_req_i;
      rsp_d.err   = sw_req_i;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sw_req_i && (sw_sel_i == SEL_W'(i))) begin
            clr[i]      = 1'b1;
            rsp_d.count = cnt[i];
            rsp_d.ovf   = ovf[i];
            rsp_d.err   = 1'b0;
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      perf_counter_ch #(
         .CNT_W    (CNT_W),
         .SATURATE (SATURATE)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .inc       (inc[g]),
         .clr_on_rd (clr[g]),
         .count     (cnt[g]),
         .ovf       (ovf[g])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) rsp_q <= '0;
      else       rsp_q <= rsp_d;
   end

   assign p_valid_o = rsp_q.valid;
   assign p_count_o = rsp_q.count;
   assign p_ovf_o   = rsp_q.ovf;
   assign p_err_o   = rsp_q.err;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Three bank configurations driven by one stimulus stream, each checked against a cycle model.
module tb_perf_counter_bank;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] trig;
   logic       en, req;
   logic [1:0] sel;

   logic       a_valid, b_valid, c_valid;
   logic [7:0] a_count;
   logic [3:0] b_count, c_count;
   logic       a_ovf, b_ovf, c_ovf;
   logic       a_err, b_err, c_err;

   always #5 clk = ~clk;

   // A: 4 ch, 8 bit, wrap.  B: 3 ch, 4 bit, wrap.  C: 4 ch, 4 bit, saturate.
   perf_counter_bank #(.NUM_CH(4), .CNT_W(8), .SATURATE(1'b0)) u_a (
      .clk(clk), .reset(reset), .cpu_trig_i(trig), .cnt_en_i(en), .sw_req_i(req),
      .sw_sel_i(sel), .p_valid_o(a_valid), .p_count_o(a_count), .p_ovf_o(a_ovf), .p_err_o(a_err));
   perf_counter_bank #(.NUM_CH(3), .CNT_W(4), .SATURATE(1'b0)) u_b (
      .clk(clk), .reset(reset), .cpu_trig_i(trig[2:0]), .cnt_en_i(en), .sw_req_i(req),
      .sw_sel_i(sel), .p_valid_o(b_valid), .p_count_o(b_count), .p_ovf_o(b_ovf), .p_err_o(b_err));
   perf_counter_bank #(.NUM_CH(4), .CNT_W(4), .SATURATE(1'b1)) u_c (
      .clk(clk), .reset(reset), .cpu_trig_i(trig), .cnt_en_i(en), .sw_req_i(req),
      .sw_sel_i(sel), .p_valid_o(c_valid), .p_count_o(c_count), .p_ovf_o(c_ovf), .p_err_o(c_err));

   typedef struct {int cnt; int ovf; int err;} exp_t;
   exp_t sbq[$];

   int n_cmp = 0, n_bad = 0;
   int mc[3][4];
   int mo[3][4];
   int nch[3] = '{4, 3, 4};
   int mw[3]  = '{8, 4, 4};
   int ms[3]  = '{0, 0, 1};

   task automatic chk(input string tag, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic check_outputs();
      int v[3], c[3], o[3], e[3];
      exp_t x;
      v = '{int'(a_valid), int'(b_valid), int'(c_valid)};
      c = '{int'(a_count), int'(b_count), int'(c_count)};
      o = '{int'(a_ovf), int'(b_ovf), int'(c_ovf)};
      e = '{int'(a_err), int'(b_err), int'(c_err)};
      for (int d = 0; d < 3; d++) begin
         if (sbq.size() > 0) begin
            x = sbq.pop_front();
            chk($sformatf("valid[%0d]", d), v[d], 1);
            chk($sformatf("count[%0d]", d), c[d], x.cnt);
            chk($sformatf("ovf[%0d]", d), o[d], x.ovf);
            chk($sformatf("err[%0d]", d), e[d], x.err);
         end else begin
            chk($sformatf("idle_valid[%0d]", d), v[d], 0);
            chk($sformatf("idle_count[%0d]", d), c[d], 0);
            chk($sformatf("idle_ovf[%0d]", d), o[d], 0);
            chk($sformatf("idle_err[%0d]", d), e[d], 0);
         end
      end
   endtask

   // Drive one cycle, advance the model, push any expected read response.
   task automatic cyc(input logic [3:0] t, input logic e, input logic r, input logic [1:0] s);
      int mx, inc;
      trig = t; en = e; req = r; sel = s;
      for (int d = 0; d < 3; d++) begin
         mx = (1 << mw[d]) - 1;
         for (int i = 0; i < nch[d]; i++) begin
            inc = int'(e & t[i]);
            if (r && int'(s) == i) begin
               sbq.push_back('{mc[d][i], mo[d][i], 0});
               mc[d][i] = inc;
               mo[d][i] = 0;
            end else if (inc != 0) begin
               if (mc[d][i] == mx) begin
                  mo[d][i] = 1;
                  mc[d][i] = (ms[d] != 0) ? mx : 0;
               end else begin
                  mc[d][i]++;
               end
            end
         end
         if (r && int'(s) >= nch[d]) sbq.push_back('{0, 0, 1});
      end
      @(posedge clk); #1;
      check_outputs();
   endtask

   task automatic do_reset(input logic r, input logic [1:0] s);
      reset = 1'b1; req = r; sel = s; trig = 4'hF; en = 1'b1;
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++)
         for (int i = 0; i < 4; i++) begin mc[d][i] = 0; mo[d][i] = 0; end
      sbq.delete();
      check_outputs();
      reset = 1'b0; req = 1'b0; trig = '0;
   endtask

   initial begin
      reset = 1'b1; trig = '0; en = 1'b0; req = 1'b0; sel = '0;
      @(posedge clk); #1;
      do_reset(1'b0, 2'd0);

      // Five events on channel 2, then two reads
      repeat (5) cyc(4'b0100, 1'b1, 1'b0, 2'd0);
      cyc(4'b0000, 1'b1, 1'b1, 2'd2);
      chk("a_ch2_five", int'(a_count), 5);
      cyc(4'b0000, 1'b1, 1'b1, 2'd2);
      chk("a_ch2_reread", int'(a_count), 0);

      // 17 events on channel 0: wrap in B, saturate in C
      repeat (17) cyc(4'b0001, 1'b1, 1'b0, 2'd0);
      cyc(4'b0000, 1'b1, 1'b1, 2'd0);
      chk("b_wrap_cnt", int'(b_count), 1);
      chk("b_wrap_ovf", int'(b_ovf), 1);
      cyc(4'b0000, 1'b1, 1'b1, 2'd0);
      chk("b_reread_ovf", int'(b_ovf), 0);

      // 20 events on channel 1
      repeat (20) cyc(4'b0010, 1'b1, 1'b0, 2'd0);
      cyc(4'b0000, 1'b1, 1'b1, 2'd1);
      chk("c_sat_cnt", int'(c_count), 15);
      chk("c_sat_ovf", int'(c_ovf), 1);

      // Channel 3 read coincident with an event; B sees an invalid select
      repeat (7) cyc(4'b1000, 1'b1, 1'b0, 2'd0);
      cyc(4'b1000, 1'b1, 1'b1, 2'd3);
      chk("a_ch3_snap", int'(a_count), 7);
      chk("b_bad_sel_err", int'(b_err), 1);
      cyc(4'b0000, 1'b1, 1'b1, 2'd3);
      chk("a_ch3_kept", int'(a_count), 1);

      // Count enable gating; a read with enable low still clears
      repeat (3) cyc(4'b1111, 1'b1, 1'b0, 2'd0);
      repeat (3) cyc(4'b1111, 1'b0, 1'b0, 2'd0);
      cyc(4'b1111, 1'b0, 1'b1, 2'd1);
      chk("a_frozen", int'(a_count), 3);
      cyc(4'b1111, 1'b0, 1'b1, 2'd1);
      for (int s = 0; s < 4; s++) cyc(4'b0000, 1'b1, 1'b1, 2'(s));

      // Random traffic with back-to-back reads
      for (int k = 0; k < 300; k++)
         cyc(4'($urandom_range(15)), 1'($urandom_range(3) != 0),
             1'($urandom_range(2) == 0), 2'($urandom_range(3)));

      // Reset while a request is issued: no response, all channels cleared
      repeat (4) cyc(4'b1111, 1'b1, 1'b0, 2'd0);
      do_reset(1'b1, 2'd1);
      chk("rst_no_valid", int'(a_valid), 0);
      for (int s = 0; s < 4; s++) cyc(4'b0000, 1'b1, 1'b1, 2'(s));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
